// File: rtl/onchip_ram_dp_pkg.sv
// onchip_ram_pkg: shared types and helpers for the dual-port on-chip RAM
package onchip_ram_pkg;
    typedef enum logic {CLEAR, READY} state_t;
    localparam int MAX_READ_LATENCY = 2;
    function automatic int lanes(input int width);
        return width / 8;
    endfunction
endpackage

// File: rtl/onchip_ram_dp_if.sv
// onchip_ram_dp_if: one Avalon-MM slave port of the dual-port RAM
interface onchip_ram_dp_if
    import onchip_ram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] address;
    logic chipselect;
    logic read;
    logic write;
    logic [lanes(DATA_W)-1:0] byteenable;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic readdatavalid;
    logic waitrequest;
    modport master(
        output address, chipselect, read, write, byteenable, writedata,
        input readdata, readdatavalid, waitrequest
    );
    modport slave(
        input address, chipselect, read, write, byteenable, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/onchip_ram_dp_core.sv
// onchip_ram_dp_core: true-dual-port byte-enabled array, reads return pre-write data
module onchip_ram_dp_core
    import onchip_ram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12,
    localparam int L = lanes(DATA_W)
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [L-1:0] be1,
    input  logic [L-1:0] be2,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [DATA_W-1:0] wdata2,
    input  logic ren1,
    input  logic ren2,
    output logic [DATA_W-1:0] q1,
    output logic [DATA_W-1:0] q2
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    // be2 arrives already masked by be1 on a same-address collision, so lane order is irrelevant
    always_ff @(posedge clk)
        if (en)
            for (int i = 0; i < L; i++) begin
                if (be1[i]) mem[addr1][i*8 +: 8] <= wdata1[i*8 +: 8];
                if (be2[i]) mem[addr2][i*8 +: 8] <= wdata2[i*8 +: 8];
            end

    always_ff @(posedge clk)
        if (reset) begin
            q1 <= '0;
            q2 <= '0;
        end else if (en) begin
            if (ren1) q1 <= mem[addr1];
            if (ren2) q2 <= mem[addr2];
        end
endmodule

// File: rtl/onchip_ram_dp.sv
// onchip_ram_dp: dual Avalon-MM port RAM with byte enables, read latency 1/2 and optional zero-fill
module onchip_ram_dp
    import onchip_ram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12,
    parameter int READ_LATENCY = 1,
    parameter int CLEAR_ON_RESET = 0,
    parameter string INIT_FILE = ""
) (
    input  logic clk,
    input  logic reset,
    input  logic clken,
    onchip_ram_dp_if.slave s1,
    onchip_ram_dp_if.slave s2,
    output logic init_busy
);
    localparam int L = lanes(DATA_W);
    localparam int LAT = (READ_LATENCY < MAX_READ_LATENCY) ? 1 : MAX_READ_LATENCY;

    state_t state;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1, q1, q2;
    logic [L-1:0] be1, be2;
    logic [LAT-1:0] v1, v2;
    logic wait_req, clr_we, w1, w2, r1, r2;

    assign wait_req = (state == CLEAR) | ~clken | reset;
    assign s1.waitrequest = wait_req;
    assign s2.waitrequest = wait_req;
    assign w1 = s1.chipselect & s1.write & ~wait_req;
    assign w2 = s2.chipselect & s2.write & ~wait_req;
    assign r1 = s1.chipselect & s1.read & ~s1.write & ~wait_req;
    assign r2 = s2.chipselect & s2.read & ~s2.write & ~wait_req;
    assign clr_we = (state == CLEAR) & clken & ~reset;

    // s1 wins every lane it enables when both ports hit the same word
    always_comb begin
        addr1 = clr_we ? clr_addr : s1.address;
        wdata1 = clr_we ? '0 : s1.writedata;
        be1 = clr_we ? '1 : (w1 ? s1.byteenable : '0);
        be2 = (w2 ? s2.byteenable : '0) & ~((s2.address == addr1) ? be1 : '0);
    end

    always_ff @(posedge clk)
        if (reset) begin
            state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            clr_addr <= '0;
            init_busy <= (CLEAR_ON_RESET != 0);
        end else if (clken && state == CLEAR) begin
            clr_addr <= clr_addr + 1'b1;
            if (&clr_addr) begin
                state <= READY;
                init_busy <= 1'b0;
            end
        end

    always_ff @(posedge clk)
        if (reset) begin
            v1 <= '0;
            v2 <= '0;
        end else if (clken) begin
            v1 <= (v1 << 1) | LAT'(r1);
            v2 <= (v2 << 1) | LAT'(r2);
        end

    assign s1.readdatavalid = v1[LAT-1];
    assign s2.readdatavalid = v2[LAT-1];

    onchip_ram_dp_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) core (
        .clk(clk),
        .reset(reset),
        .en(clken),
        .addr1(addr1),
        .addr2(s2.address),
        .be1(be1),
        .be2(be2),
        .wdata1(wdata1),
        .wdata2(s2.writedata),
        .ren1(r1),
        .ren2(r2),
        .q1(q1),
        .q2(q2)
    );

    if (LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] d1, d2;
        always_ff @(posedge clk)
            if (reset) begin
                d1 <= '0;
                d2 <= '0;
            end else if (clken) begin
                d1 <= q1;
                d2 <= q2;
            end
        assign s1.readdata = d1;
        assign s2.readdata = d2;
    end else begin : g_lat1
        assign s1.readdata = q1;
        assign s2.readdata = q2;
    end
endmodule

// File: tb/tb_onchip_ram_dp.sv
// tb_onchip_ram_dp: directed checks of two zero-filling 16-word RAMs (latency 1 and 2) driven in lockstep
module tb_onchip_ram_dp;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clken = 1'b1;
    logic busy_a, busy_b;
    int checks = 0;
    int failures = 0;

    onchip_ram_dp_if #(.DATA_W(32), .ADDR_W(4)) a1();
    onchip_ram_dp_if #(.DATA_W(32), .ADDR_W(4)) a2();
    onchip_ram_dp_if #(.DATA_W(32), .ADDR_W(4)) b1();
    onchip_ram_dp_if #(.DATA_W(32), .ADDR_W(4)) b2();

    onchip_ram_dp #(.DATA_W(32), .ADDR_W(4), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut_a (
        .clk(clk), .reset(reset), .clken(clken), .s1(a1), .s2(a2), .init_busy(busy_a)
    );
    onchip_ram_dp #(.DATA_W(32), .ADDR_W(4), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut_b (
        .clk(clk), .reset(reset), .clken(clken), .s1(b1), .s2(b2), .init_busy(busy_b)
    );

    assign b1.address = a1.address;
    assign b1.chipselect = a1.chipselect;
    assign b1.read = a1.read;
    assign b1.write = a1.write;
    assign b1.byteenable = a1.byteenable;
    assign b1.writedata = a1.writedata;
    assign b2.address = a2.address;
    assign b2.chipselect = a2.chipselect;
    assign b2.read = a2.read;
    assign b2.write = a2.write;
    assign b2.byteenable = a2.byteenable;
    assign b2.writedata = a2.writedata;

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        a1.chipselect = 1'b0; a1.read = 1'b0; a1.write = 1'b0;
        a1.address = '0; a1.byteenable = '0; a1.writedata = '0;
        a2.chipselect = 1'b0; a2.read = 1'b0; a2.write = 1'b0;
        a2.address = '0; a2.byteenable = '0; a2.writedata = '0;
    endtask

    task automatic set_rd(input int p, input logic [3:0] ad);
        if (p == 1) begin
            a1.chipselect = 1'b1; a1.read = 1'b1; a1.write = 1'b0; a1.address = ad;
        end else begin
            a2.chipselect = 1'b1; a2.read = 1'b1; a2.write = 1'b0; a2.address = ad;
        end
    endtask

    task automatic set_wr(input int p, input logic [3:0] ad, input logic [31:0] d, input logic [3:0] be);
        if (p == 1) begin
            a1.chipselect = 1'b1; a1.read = 1'b0; a1.write = 1'b1;
            a1.address = ad; a1.writedata = d; a1.byteenable = be;
        end else begin
            a2.chipselect = 1'b1; a2.read = 1'b0; a2.write = 1'b1;
            a2.address = ad; a2.writedata = d; a2.byteenable = be;
        end
    endtask

    // issues one read and returns what both DUTs show one and two cycles later
    task automatic do_read(input int p, input logic [3:0] ad, output logic [3:0] vv,
                           output logic [31:0] da, output logic [31:0] db);
        set_rd(p, ad);
        tick;
        idle;
        vv[3] = (p == 1) ? a1.readdatavalid : a2.readdatavalid;
        vv[2] = (p == 1) ? b1.readdatavalid : b2.readdatavalid;
        da = (p == 1) ? a1.readdata : a2.readdata;
        tick;
        vv[1] = (p == 1) ? a1.readdatavalid : a2.readdatavalid;
        vv[0] = (p == 1) ? b1.readdatavalid : b2.readdatavalid;
        db = (p == 1) ? b1.readdata : b2.readdata;
    endtask

    task automatic test_reset;
        int n;
        logic bad;
        reset = 1'b1;
        clken = 1'b1;
        idle;
        tick;
        tick;
        checks++;
        if ({a1.readdatavalid, a2.readdatavalid, b1.readdatavalid, b2.readdatavalid} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_valid got=%b want=0000",
                     {a1.readdatavalid, a2.readdatavalid, b1.readdatavalid, b2.readdatavalid});
        end
        checks++;
        if ({a1.readdata, a2.readdata, b1.readdata, b2.readdata} !== 128'h0) begin
            failures++;
            $display("FAIL reset_readdata got=%h want=0", {a1.readdata, a2.readdata, b1.readdata, b2.readdata});
        end
        checks++;
        if ({a1.waitrequest, a2.waitrequest, b1.waitrequest, b2.waitrequest} !== 4'b1111) begin
            failures++;
            $display("FAIL reset_wait got=%b want=1111",
                     {a1.waitrequest, a2.waitrequest, b1.waitrequest, b2.waitrequest});
        end
        checks++;
        if ({busy_a, busy_b} !== 2'b11) begin
            failures++;
            $display("FAIL reset_busy got=%b want=11", {busy_a, busy_b});
        end
        reset = 1'b0;
        n = 0;
        bad = 1'b0;
        do begin
            tick;
            n++;
            if (a1.waitrequest && busy_a !== 1'b1) bad = 1'b1;
        end while (a1.waitrequest && n < 100);
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL clear_cycles got=%0d want=16", n);
        end
        checks++;
        if ({a2.waitrequest, b1.waitrequest, b2.waitrequest, busy_a, busy_b, bad} !== 6'b0) begin
            failures++;
            $display("FAIL clear_end got=%b want=000000",
                     {a2.waitrequest, b1.waitrequest, b2.waitrequest, busy_a, busy_b, bad});
        end
    endtask

    task automatic test_clear_zero;
        logic [3:0] vv;
        logic [31:0] da, db;
        for (int i = 0; i < 16; i++) begin
            do_read(1 + (i % 2), 4'(i), vv, da, db);
            checks++;
            if (vv !== 4'b1001 || da !== 32'h0 || db !== 32'h0) begin
                failures++;
                $display("FAIL clear_zero[%0d] valid=%b a=%h b=%h want valid=1001 data=0", i, vv, da, db);
            end
        end
    endtask

    task automatic test_write_read;
        logic [3:0] vv;
        logic [31:0] da, db;
        set_wr(1, 4'd5, 32'hDEADBEEF, 4'hF);
        tick;
        idle;
        do_read(2, 4'd5, vv, da, db);
        checks++;
        if (vv !== 4'b1001 || da !== 32'hDEADBEEF || db !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL write_read valid=%b a=%h b=%h want valid=1001 data=deadbeef", vv, da, db);
        end
    endtask

    task automatic test_collision;
        logic [3:0] vv;
        logic [31:0] da, db;
        set_wr(1, 4'd3, 32'h11223344, 4'hF);
        tick;
        set_wr(1, 4'd3, 32'hAAAAAAAA, 4'b0011);
        set_wr(2, 4'd3, 32'hBBBBBBBB, 4'b0110);
        tick;
        idle;
        do_read(1, 4'd3, vv, da, db);
        checks++;
        if (vv !== 4'b1001 || da !== 32'h11BBAAAA || db !== 32'h11BBAAAA) begin
            failures++;
            $display("FAIL collision valid=%b a=%h b=%h want valid=1001 data=11bbaaaa", vv, da, db);
        end
    endtask

    task automatic test_rdw;
        logic [3:0] vv;
        logic [31:0] da, db;
        set_wr(1, 4'd7, 32'h1, 4'hF);
        tick;
        set_wr(1, 4'd7, 32'h2, 4'hF);
        set_rd(2, 4'd7);
        tick;
        idle;
        checks++;
        if (a2.readdatavalid !== 1'b1 || a2.readdata !== 32'h1) begin
            failures++;
            $display("FAIL rdw_old_a valid=%b data=%h want 1/00000001", a2.readdatavalid, a2.readdata);
        end
        tick;
        checks++;
        if (b2.readdatavalid !== 1'b1 || b2.readdata !== 32'h1) begin
            failures++;
            $display("FAIL rdw_old_b valid=%b data=%h want 1/00000001", b2.readdatavalid, b2.readdata);
        end
        do_read(2, 4'd7, vv, da, db);
        checks++;
        if (vv !== 4'b1001 || da !== 32'h2 || db !== 32'h2) begin
            failures++;
            $display("FAIL rdw_new valid=%b a=%h b=%h want valid=1001 data=2", vv, da, db);
        end
        set_wr(1, 4'd7, 32'h3, 4'hF);
        a1.read = 1'b1;
        tick;
        idle;
        vv[3] = a1.readdatavalid;
        vv[2] = b1.readdatavalid;
        tick;
        vv[1] = a1.readdatavalid;
        vv[0] = b1.readdatavalid;
        checks++;
        if (vv !== 4'b0000) begin
            failures++;
            $display("FAIL rw_no_resp valid=%b want=0000", vv);
        end
        do_read(1, 4'd7, vv, da, db);
        checks++;
        if (vv !== 4'b1001 || da !== 32'h3 || db !== 32'h3) begin
            failures++;
            $display("FAIL rw_write valid=%b a=%h b=%h want valid=1001 data=3", vv, da, db);
        end
    endtask

    task automatic test_clken;
        logic [31:0] qa[$];
        logic [31:0] qb[$];
        for (int i = 0; i < 4; i++) begin
            set_wr(2, 4'(8 + i), 32'hC0DE0000 | 32'(8 + i), 4'hF);
            tick;
        end
        idle;
        for (int c = 0; c < 14; c++) begin
            clken = !(c >= 2 && c <= 4);
            idle;
            if (c <= 1) set_rd(1, 4'(8 + c));
            else if (c <= 5) set_rd(1, 4'd10);
            else if (c == 6) set_rd(1, 4'd11);
            if (clken && a1.readdatavalid) qa.push_back(a1.readdata);
            if (clken && b1.readdatavalid) qb.push_back(b1.readdata);
            tick;
        end
        clken = 1'b1;
        idle;
        checks++;
        if (qa.size() != 4 || qb.size() != 4) begin
            failures++;
            $display("FAIL clken_count a=%0d b=%0d want 4/4", qa.size(), qb.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= qa.size() || i >= qb.size() || qa[i] !== (32'hC0DE0000 | 32'(8 + i)) ||
                qb[i] !== (32'hC0DE0000 | 32'(8 + i))) begin
                failures++;
                $display("FAIL clken_order[%0d] a=%h b=%h want=%h", i,
                         (i < qa.size()) ? qa[i] : 32'hx, (i < qb.size()) ? qb[i] : 32'hx,
                         32'hC0DE0000 | 32'(8 + i));
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] qa1[$];
        logic [31:0] qa2[$];
        logic [31:0] qb1[$];
        logic [31:0] qb2[$];
        for (int i = 0; i < 8; i++) begin
            set_wr(1, 4'(i), 32'h10000000 + 32'(i * 32'h111), 4'hF);
            set_wr(2, 4'(8 + i), 32'h20000000 + 32'(i), 4'hF);
            tick;
        end
        idle;
        for (int c = 0; c < 12; c++) begin
            idle;
            if (c < 8) begin
                set_rd(1, 4'(8 + c));
                set_rd(2, 4'(c));
            end
            if (a1.readdatavalid) qa1.push_back(a1.readdata);
            if (a2.readdatavalid) qa2.push_back(a2.readdata);
            if (b1.readdatavalid) qb1.push_back(b1.readdata);
            if (b2.readdatavalid) qb2.push_back(b2.readdata);
            tick;
        end
        idle;
        checks++;
        if (qa1.size() != 8 || qa2.size() != 8 || qb1.size() != 8 || qb2.size() != 8) begin
            failures++;
            $display("FAIL b2b_count got=%0d/%0d/%0d/%0d want 8 each",
                     qa1.size(), qa2.size(), qb1.size(), qb2.size());
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= qa1.size() || i >= qa2.size() || i >= qb1.size() || i >= qb2.size() ||
                qa1[i] !== 32'h20000000 + 32'(i) || qb1[i] !== 32'h20000000 + 32'(i) ||
                qa2[i] !== 32'h10000000 + 32'(i * 32'h111) || qb2[i] !== 32'h10000000 + 32'(i * 32'h111)) begin
                failures++;
                $display("FAIL b2b[%0d] s1=%h/%h want %h s2=%h/%h want %h", i,
                         (i < qa1.size()) ? qa1[i] : 32'hx, (i < qb1.size()) ? qb1[i] : 32'hx,
                         32'h20000000 + 32'(i),
                         (i < qa2.size()) ? qa2[i] : 32'hx, (i < qb2.size()) ? qb2[i] : 32'hx,
                         32'h10000000 + 32'(i * 32'h111));
            end
        end
    endtask

    task automatic test_reset_inflight;
        int n;
        logic seen;
        logic [3:0] vv;
        logic [31:0] da, db;
        set_rd(1, 4'd5);
        set_rd(2, 4'd3);
        tick;
        idle;
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (a1.readdatavalid || a2.readdatavalid || b1.readdatavalid || b2.readdatavalid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL inflight_discard got=%b want=0", seen);
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        checks++;
        if ({busy_a, busy_b, a1.waitrequest, b2.waitrequest} !== 4'b1111) begin
            failures++;
            $display("FAIL mid_clear got=%b want=1111", {busy_a, busy_b, a1.waitrequest, b2.waitrequest});
        end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        n = 0;
        do begin
            tick;
            n++;
        end while (a1.waitrequest && n < 100);
        checks++;
        if (n != 16 || {busy_a, busy_b} !== 2'b00) begin
            failures++;
            $display("FAIL restart_cycles got=%0d busy=%b want=16 busy=00", n, {busy_a, busy_b});
        end
        for (int i = 0; i < 4; i++) begin
            do_read(2 - (i % 2), 4'(3 + 2 * i), vv, da, db);
            checks++;
            if (vv !== 4'b1001 || da !== 32'h0 || db !== 32'h0) begin
                failures++;
                $display("FAIL refill_zero[%0d] valid=%b a=%h b=%h want valid=1001 data=0", 3 + 2 * i, vv, da, db);
            end
        end
    endtask

    initial begin
        idle;
        test_reset;
        test_clear_zero;
        test_write_read;
        test_collision;
        test_rdw;
        test_clken;
        test_back_to_back;
        test_reset_inflight;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
